// File: rtl/btn_conditioner.sv
// Conditions four raw push-buttons {up, down, left, right}: two-flop synchronizer,
// debounce filter, single-cycle press/release pulses and optional hold-to-repeat.
module btn_conditioner #(
    parameter int          DEBOUNCE_CYCLES = 2_000_000,
    parameter int          REPEAT_DELAY    = 50_000_000,
    parameter int          REPEAT_PERIOD   = 15_000_000,
    parameter logic [3:0]  REPEAT_EN       = 4'b1111,
    parameter int          CNT_W           = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_in,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic [3:0] btn_release
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_REPEAT,
        ST_RELEASE_WAIT
    } state_t;

    // Thresholds are compared one bit wider than the counter so that the
    // incremented value can never wrap before the comparison.
    localparam logic [CNT_W:0]   DEB     = (CNT_W+1)'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W:0]   DEL     = (CNT_W+1)'(REPEAT_DELAY);
    localparam logic [CNT_W:0]   PER     = (CNT_W+1)'(REPEAT_PERIOD);
    localparam logic [CNT_W:0]   INC_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] sync1;
    logic [3:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_btn
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] cnt_sat;
        logic [CNT_W:0]   cnt_inc;
        logic [CNT_W:0]   thresh;
        logic             level_q, level_d;
        logic             pulse_q, pulse_d;
        logic             rel_q, rel_d;
        logic             s;

        assign s       = sync2[i];
        assign cnt_inc = {1'b0, cnt_q} + INC_ONE;
        assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
        assign thresh  = (state_q == ST_REPEAT) ? PER : DEL;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
                rel_q   <= rel_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            pulse_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (s) begin
                        state_d = ST_PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if ({1'b0, cnt_q} >= DEB) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                        level_d = 1'b1;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                ST_HELD, ST_REPEAT: begin
                    // A release sample wins over a repeat falling on the same cycle.
                    if (!s) begin
                        state_d = ST_RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end else if (REPEAT_EN[i] && (cnt_inc >= thresh)) begin
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if ({1'b0, cnt_q} >= DEB) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_pulse[i]   = pulse_q;
        assign btn_release[i] = rel_q;
    end

endmodule
